// File: rtl/detector_event_pkg.sv
// rtl/detector_event_pkg.sv - shared types and widths for the detector event sequencer
//
// Purpose: sequencer state encoding and the fixed detector/timestamp widths.
// Ports:   none (package).

package detector_event_pkg;

    localparam int DET_WIDTH = 64;
    localparam int TS_WIDTH  = 64;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WINDOW,
        ST_SEND_TS,
        ST_SEND_HITS,
        ST_DEAD
    } det_state_t;

endpackage

// File: rtl/detector_event_sequencer_if.sv
// rtl/detector_event_sequencer_if.sv - event output stream interface
//
// Purpose: stream carrying the two-beat event packet (timestamp, hit pattern).
// Signals: tdata  - beat data
//          tvalid - beat valid
//          tlast  - high on the hit-pattern beat
//          tready - downstream ready
// Modports: master (sequencer side), slave (sink side).

interface detector_event_sequencer_if;
    import detector_event_pkg::*;

    logic [DET_WIDTH-1:0] tdata;
    logic                 tvalid;
    logic                 tlast;
    logic                 tready;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);

endinterface

// File: rtl/det_status_counter.sv
// rtl/det_status_counter.sv - wrapping status counter with increment enable
//
// Purpose: free-running event counter that wraps at 2^WIDTH.
// Ports:   clk   - clock
//          rst   - synchronous active-high reset, clears the count
//          inc   - add one this cycle
//          count - current count

module det_status_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc) begin
            count_d = count_q + ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/detector_event_sequencer.sv
// rtl/detector_event_sequencer.sv - per-event trigger, coincidence window and packet sequencer
//
// Purpose: triggers on any masked detector hit, ORs masked hits over a
//          programmable window, emits a timestamp beat and a hit-pattern beat,
//          then holds off for a programmable dead time.
// Ports:   aclk, areset       - clock, synchronous active-high reset
//          cfg_enable         - trigger enable
//          cfg_mask           - channel mask (1 = participates)
//          cfg_window         - extra accumulation cycles after the trigger cycle
//          cfg_deadtime       - hold-off cycles after the last beat is accepted
//          det_data           - raw detector hits
//          m_axis             - event stream (master)
//          sts_events         - completed packets
//          sts_dropped        - masked-hit cycles lost while busy

module detector_event_sequencer
    import detector_event_pkg::*;
#(
    parameter int CNTR_WIDTH = 8,
    parameter int STS_WIDTH  = 32
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic                  cfg_enable,
    input  logic [DET_WIDTH-1:0]  cfg_mask,
    input  logic [CNTR_WIDTH-1:0] cfg_window,
    input  logic [CNTR_WIDTH-1:0] cfg_deadtime,
    input  logic [DET_WIDTH-1:0]  det_data,
    detector_event_sequencer_if.master m_axis,
    output logic [STS_WIDTH-1:0]  sts_events,
    output logic [STS_WIDTH-1:0]  sts_dropped
);

    localparam logic [CNTR_WIDTH-1:0] CNTR_ONE = {{(CNTR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [TS_WIDTH-1:0]   TS_ONE   = {{(TS_WIDTH-1){1'b0}}, 1'b1};

    det_state_t            state_q,   state_d;
    logic [CNTR_WIDTH-1:0] cntr_q,    cntr_d;
    logic [CNTR_WIDTH-1:0] win_l_q,   win_l_d;
    logic [CNTR_WIDTH-1:0] dead_l_q,  dead_l_d;
    logic [TS_WIDTH-1:0]   ts_cnt_q,  ts_cnt_d;
    logic [TS_WIDTH-1:0]   ts_q,      ts_d;
    logic [DET_WIDTH-1:0]  acc_q,     acc_d;
    logic [DET_WIDTH-1:0]  det_reg_q, det_reg_d;

    logic [DET_WIDTH-1:0]  hit;
    logic                  hit_any;
    logic                  ev_inc;
    logic                  drop_inc;
    logic [DET_WIDTH-1:0]  tdata;
    logic                  tvalid;
    logic                  tlast;

    // The mask is applied live so a mask change takes effect on the
    // registered sample already in flight.
    assign hit     = det_reg_q & cfg_mask;
    assign hit_any = |hit;

    always_comb begin
        state_d   = state_q;
        cntr_d    = cntr_q;
        win_l_d   = win_l_q;
        dead_l_d  = dead_l_q;
        ts_cnt_d  = ts_cnt_q + TS_ONE;
        ts_d      = ts_q;
        acc_d     = acc_q;
        det_reg_d = det_data;
        ev_inc    = 1'b0;
        drop_inc  = 1'b0;
        tdata     = '0;
        tvalid    = 1'b0;
        tlast     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cfg_enable && hit_any) begin
                    ts_d     = ts_cnt_q;
                    acc_d    = hit;
                    win_l_d  = cfg_window;
                    dead_l_d = cfg_deadtime;
                    if (cfg_window == '0) begin
                        state_d = ST_SEND_TS;
                    end else begin
                        state_d = ST_WINDOW;
                        cntr_d  = CNTR_ONE;
                    end
                end
            end

            // Window runs to completion even if cfg_enable drops meanwhile.
            ST_WINDOW: begin
                acc_d = acc_q | hit;
                if (cntr_q == win_l_q) begin
                    state_d = ST_SEND_TS;
                end else begin
                    cntr_d = cntr_q + CNTR_ONE;
                end
            end

            ST_SEND_TS: begin
                tvalid   = 1'b1;
                tdata    = ts_q;
                drop_inc = hit_any;
                if (m_axis.tready) begin
                    state_d = ST_SEND_HITS;
                end
            end

            ST_SEND_HITS: begin
                tvalid   = 1'b1;
                tdata    = acc_q;
                tlast    = 1'b1;
                drop_inc = hit_any;
                if (m_axis.tready) begin
                    ev_inc = 1'b1;
                    if (dead_l_q == '0) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DEAD;
                        cntr_d  = CNTR_ONE;
                    end
                end
            end

            ST_DEAD: begin
                drop_inc = hit_any;
                if (cntr_q == dead_l_q) begin
                    state_d = ST_IDLE;
                end else begin
                    cntr_d = cntr_q + CNTR_ONE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q   <= ST_IDLE;
            cntr_q    <= '0;
            win_l_q   <= '0;
            dead_l_q  <= '0;
            ts_cnt_q  <= '0;
            ts_q      <= '0;
            acc_q     <= '0;
            det_reg_q <= '0;
        end else begin
            state_q   <= state_d;
            cntr_q    <= cntr_d;
            win_l_q   <= win_l_d;
            dead_l_q  <= dead_l_d;
            ts_cnt_q  <= ts_cnt_d;
            ts_q      <= ts_d;
            acc_q     <= acc_d;
            det_reg_q <= det_reg_d;
        end
    end

    // Beat data comes straight from held registers, so it stays stable
    // for as long as the beat waits on tready.
    assign m_axis.tdata  = tdata;
    assign m_axis.tvalid = tvalid;
    assign m_axis.tlast  = tlast;

    det_status_counter #(
        .WIDTH (STS_WIDTH)
    ) u_events_cnt (
        .clk   (aclk),
        .rst   (areset),
        .inc   (ev_inc),
        .count (sts_events)
    );

    det_status_counter #(
        .WIDTH (STS_WIDTH)
    ) u_dropped_cnt (
        .clk   (aclk),
        .rst   (areset),
        .inc   (drop_inc),
        .count (sts_dropped)
    );

endmodule
